// File: rtl/nq_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds the arbiter state/grant enums and the read-data pattern returned on an aborted access.
package nq_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    localparam logic [DEF_DATA_W-1:0] ERR_RDATA = '1;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        D_BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        FETCH,
        DATA
    } grant_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Busy-cycle watchdog for the memory arbiter; counts cycles spent waiting on mem_rdy.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    // expired fires on the last permitted busy cycle, so the abort lands after exactly TIMEOUT_CYC cycles
    assign expired = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and load/store.
// Optional busy-wait abort is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter
    import nq_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 15
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_data,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              stall_flg,
    output logic              err
);

    arb_state_t        state, state_n;
    grant_t            last_grant, grant_n;
    logic              mem_en_n, mem_we_n, if_ack_n, d_ack_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, if_data_n, d_rdata_n;
    logic              d_req;

    assign d_req     = d_rd | d_wr;
    assign stall_flg = (if_req & ~if_ack) | (d_req & ~d_ack);

`ifdef MEM_TIMEOUT_EN
    localparam logic [DATA_W-1:0] ERR_FILL = DATA_W'(ERR_RDATA);

    logic busy, timeout_hit, err_q, err_n;

    assign busy = (state == IF_BUSY) || (state == D_BUSY);
    assign err  = err_q;

    mem_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .enable (busy),
        .expired(timeout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= FETCH;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_data    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_n;
            last_grant <= grant_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            if_ack     <= if_ack_n;
            d_ack      <= d_ack_n;
            if_data    <= if_data_n;
            d_rdata    <= d_rdata_n;
        end
    end

    // Data wins a tie unless it had the previous grant, so fetch can never be starved
    always_comb begin
        state_n     = state;
        grant_n     = last_grant;
        mem_en_n    = mem_en;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_ack_n    = 1'b0;
        d_ack_n     = 1'b0;
        if_data_n   = if_data;
        d_rdata_n   = d_rdata;
`ifdef MEM_TIMEOUT_EN
        err_n       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (d_req && (!if_req || last_grant == FETCH)) begin
                    state_n     = D_BUSY;
                    grant_n     = DATA;
                    mem_en_n    = 1'b1;
                    mem_we_n    = d_wr;
                    mem_addr_n  = d_addr;
                    mem_wdata_n = d_wdata;
                end else if (if_req) begin
                    state_n    = IF_BUSY;
                    grant_n    = FETCH;
                    mem_en_n   = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = if_addr;
                end
            end
            IF_BUSY: begin
                if (mem_rdy) begin
                    if_data_n = mem_rdata;
                    mem_en_n  = 1'b0;
                    mem_we_n  = 1'b0;
                    if_ack_n  = 1'b1;
                    state_n   = RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    if_data_n = ERR_FILL;
                    mem_en_n  = 1'b0;
                    mem_we_n  = 1'b0;
                    if_ack_n  = 1'b1;
                    err_n     = 1'b1;
                    state_n   = RESP;
                end
`endif
            end
            D_BUSY: begin
                if (mem_rdy) begin
                    if (!mem_we) begin
                        d_rdata_n = mem_rdata;
                    end
                    mem_en_n = 1'b0;
                    mem_we_n = 1'b0;
                    d_ack_n  = 1'b1;
                    state_n  = RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    d_rdata_n = ERR_FILL;
                    mem_en_n  = 1'b0;
                    mem_we_n  = 1'b0;
                    d_ack_n   = 1'b1;
                    err_n     = 1'b1;
                    state_n   = RESP;
                end
`endif
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand-written multi-cycle sequences.
// The timeout sequence is only compiled when MEM_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_data;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
    logic        stall_flg;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_data  (if_data),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy),
        .stall_flg(stall_flg),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_rd;
        logic        d_wr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] mem_rdata;
        logic        mem_rdy;
        logic        e_en;
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_if_ack;
        logic [15:0] e_if_data;
        logic        e_d_ack;
        logic [15:0] e_d_rdata;
        logic        e_stall;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_rdy   = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        d_rd      = v.d_rd;
        d_wr      = v.d_wr;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        mem_rdata = v.mem_rdata;
        mem_rdy   = v.mem_rdy;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("row%0d mem_en", idx),    32'(mem_en),    32'(v.e_en));
        checkVal($sformatf("row%0d mem_we", idx),    32'(mem_we),    32'(v.e_we));
        checkVal($sformatf("row%0d mem_addr", idx),  32'(mem_addr),  32'(v.e_addr));
        checkVal($sformatf("row%0d mem_wdata", idx), 32'(mem_wdata), 32'(v.e_wdata));
        checkVal($sformatf("row%0d if_ack", idx),    32'(if_ack),    32'(v.e_if_ack));
        checkVal($sformatf("row%0d if_data", idx),   32'(if_data),   32'(v.e_if_data));
        checkVal($sformatf("row%0d d_ack", idx),     32'(d_ack),     32'(v.e_d_ack));
        checkVal($sformatf("row%0d d_rdata", idx),   32'(d_rdata),   32'(v.e_d_rdata));
        checkVal($sformatf("row%0d stall_flg", idx), 32'(stall_flg), 32'(v.e_stall));
        checkVal($sformatf("row%0d err", idx),       32'(err),       32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  en_cnt;
        int  ack_cnt;
        bit  got;
        bit  is_data;
        int  phase;

        // inputs: if_req if_addr d_rd d_wr d_addr d_wdata mem_rdata mem_rdy | en we addr wdata if_ack if_data d_ack d_rdata stall
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[3]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[4]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4A21, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[5]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h4A21, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h4A21, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h4A21, 1'b0, 16'h0000, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h4A21, 1'b0, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h4A21, 1'b1, 16'h1234, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h4A21, 1'b0, 16'h1234, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h4A21, 1'b0, 16'h1234, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 16'hBEEF, 16'h5555, 1'b1, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 1'b0, 16'h4A21, 1'b0, 16'h1234, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0200, 16'hBEEF, 1'b0, 16'h4A21, 1'b1, 16'h1234, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0200, 16'hBEEF, 1'b0, 16'h4A21, 1'b0, 16'h1234, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h9999, 1'b1, 1'b0, 1'b0, 16'h0200, 16'hBEEF, 1'b0, 16'h4A21, 1'b0, 16'h1234, 1'b0};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0200, 16'hBEEF, 1'b0, 16'h4A21, 1'b0, 16'h1234, 1'b0};

        clk = 1'b0;
        rst = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] table: fetch read, data read, write, stray mem_rdy");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
            tick();
        end

        // Both requesters held from reset: grants must alternate DATA, FETCH, DATA, FETCH
        $display("[TB] sequence: alternating grants");
        rst = 1'b1;
        #1;
        rst = 1'b0;
        if_req    = 1'b1;
        if_addr   = 16'h0400;
        d_rd      = 1'b1;
        d_addr    = 16'h0500;
        mem_rdata = 16'h0ACE;
        mem_rdy   = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            phase   = c % 3;
            is_data = ((c / 3) % 2) == 0;
            checkVal($sformatf("alt c%0d mem_en", c), 32'(mem_en), 32'(phase == 1));
            if (phase == 1) begin
                checkVal($sformatf("alt c%0d mem_addr", c), 32'(mem_addr), is_data ? 32'h0500 : 32'h0400);
            end
            checkVal($sformatf("alt c%0d d_ack", c),  32'(d_ack),  32'(phase == 2 && is_data));
            checkVal($sformatf("alt c%0d if_ack", c), 32'(if_ack), 32'(phase == 2 && !is_data));
            tick();
        end
        checkVal("alt if_data", 32'(if_data), 32'h0ACE);
        checkVal("alt d_rdata", 32'(d_rdata), 32'h0ACE);
        clearInputs();
        tick();

        // Reset mid-access aborts without an ack; the re-issued read then completes
        $display("[TB] sequence: reset during D_BUSY");
        d_rd   = 1'b1;
        d_addr = 16'h0300;
        tick();
        checkVal("rstmid busy mem_en", 32'(mem_en), 32'd1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkVal("rstmid async mem_en", 32'(mem_en), 32'd0);
        checkVal("rstmid async d_ack", 32'(d_ack), 32'd0);
        tick();
        checkVal("rstmid held d_ack", 32'(d_ack), 32'd0);
        checkVal("rstmid held mem_en", 32'(mem_en), 32'd0);
        rst       = 1'b0;
        mem_rdy   = 1'b1;
        mem_rdata = 16'h7777;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (d_ack) begin
                got = 1'b1;
                checkVal("rstmid reissue d_rdata", 32'(d_rdata), 32'h7777);
                checkVal("rstmid reissue mem_addr", 32'(mem_addr), 32'h0300);
            end
        end
        checkVal("rstmid reissue ack seen", 32'(got), 32'd1);
        clearInputs();
        tick();

        // Simultaneous read and write is a single write access
        $display("[TB] sequence: d_rd and d_wr together");
        d_rd    = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0050;
        d_wdata = 16'h1357;
        mem_rdy = 1'b1;
        en_cnt  = 0;
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_en) begin
                en_cnt++;
                checkVal("rdwr mem_we", 32'(mem_we), 32'd1);
                checkVal("rdwr mem_addr", 32'(mem_addr), 32'h0050);
                checkVal("rdwr mem_wdata", 32'(mem_wdata), 32'h1357);
            end
            if (d_ack) begin
                ack_cnt++;
                d_rd = 1'b0;
                d_wr = 1'b0;
            end
        end
        checkVal("rdwr access count", 32'(en_cnt), 32'd1);
        checkVal("rdwr d_ack count", 32'(ack_cnt), 32'd1);
        checkVal("rdwr d_rdata kept", 32'(d_rdata), 32'h7777);
        clearInputs();
        tick();

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: abort after 15 busy cycles with err and all-ones data
        $display("[TB] sequence: timeout abort");
        d_rd   = 1'b1;
        d_addr = 16'h0600;
        en_cnt = 0;
        got    = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (mem_en) begin
                en_cnt++;
            end
            if (d_ack) begin
                got = 1'b1;
                checkVal("timeout err", 32'(err), 32'd1);
                checkVal("timeout d_rdata", 32'(d_rdata), 32'hFFFF);
            end
        end
        checkVal("timeout ack seen", 32'(got), 32'd1);
        checkVal("timeout busy cycles", 32'(en_cnt), 32'd15);
        clearInputs();
        tick();
        checkVal("timeout err drops", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch stage and the load/store path.
- The load/store path is qualified by the main controller's memRd_flg/memWrt_flg.
- Sequences multi-cycle memory accesses with a ready handshake.
- Drives stall_flg back to the main controller while either requester waits.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
TIMEOUT_CYC, 15, max cycles waiting on mem_rdy (only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  fetch request; held until if_ack
if_addr  input  ADDR_W  fetch address
if_ack  output  1  one-cycle pulse; if_data valid this cycle
if_data  output  DATA_W  fetched instruction word
d_rd  input  1  data read request (memRd_flg); held until d_ack
d_wr  input  1  data write request (memWrt_flg); held until d_ack
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ack  output  1  one-cycle pulse; d_rdata valid this cycle on reads
d_rdata  output  DATA_W  load data
mem_en  output  1  memory access strobe
mem_we  output  1  write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_rdy
mem_rdy  input  1  memory completion, sampled while mem_en=1
stall_flg  output  1  pipeline stall request to the main controller
err  output  1  one-cycle timeout pulse (MEM_TIMEOUT_EN only, else tied 0)

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, last_grant=FETCH.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ack=0, d_ack=0, if_data=0, d_rdata=0, err=0.
- States: IDLE, IF_BUSY, D_BUSY, RESP.
- IDLE:
  - Data request only → D_BUSY; fetch request only → IF_BUSY.
  - Both pending: data wins unless last_grant=DATA, in which case fetch wins (no fetch starvation).
  - On grant, register mem_en=1, mem_addr, mem_we=d_wr, mem_wdata; update last_grant.
- IF_BUSY / D_BUSY:
  - Hold mem_en and all mem_* outputs stable until mem_rdy=1.
  - On mem_rdy=1: latch mem_rdata into if_data or d_rdata (reads only), drop mem_en, go to RESP.
- RESP:
  - Pulse if_ack or d_ack for exactly one cycle, then return to IDLE.
  - No back-to-back grant; minimum 1 idle cycle between accesses.
- Latency: request seen at cycle 0 → mem_en high at cycle 1 → mem_rdy at cycle k (k≥1) → ack at cycle k+1.
- Writes: d_rdata holds its previous value; d_ack still pulses.
- d_rd=d_wr=1 simultaneously: treated as a write (mem_we=1).
- Requests dropped before ack: the access already issued completes; its ack is still pulsed and ignored.
- stall_flg is combinational: (if_req & ~if_ack) | ((d_rd|d_wr) & ~d_ack). It is 0 in the ack cycle.
- mem_rdy while mem_en=0: ignored.
- rst mid-access: immediate return to IDLE, mem_en=0, no ack issued; requesters re-issue.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter runs in IF_BUSY/D_BUSY and clears on grant.
  - If TIMEOUT_CYC cycles elapse without mem_rdy: abort, drop mem_en, load all-ones into the read-data register, go to RESP, and pulse err together with the ack.
- MEM_TIMEOUT_EN undefined: no counter; busy states wait indefinitely; err tied 0.

Decomposition:
- Package nq_mem_pkg:
  - arbiter state enum (IDLE, IF_BUSY, D_BUSY, RESP)
  - grant enum (FETCH, DATA)
  - default ADDR_W/DATA_W constants
  - ERR_RDATA all-ones constant
- One sub-module: mem_timeout_counter (load/clear/expire), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Reset then if_req=1, if_addr=0x0010, mem_rdy 2 cycles after mem_en, mem_rdata=0x4A21 → mem_en at cycle 1, if_ack at cycle 4 with if_data=0x4A21; stall_flg=1 for cycles 0-3, 0 at cycle 4.
- d_wr=1, d_addr=0x0200, d_wdata=0xBEEF, mem_rdy immediate → mem_we=1, mem_addr=0x0200, mem_wdata=0xBEEF, d_ack one pulse, d_rdata unchanged.
- if_req and d_rd held together continuously → grants alternate DATA, FETCH, DATA…; every ack is a single-cycle pulse.
- rst asserted while in D_BUSY → mem_en=0 asynchronously, no d_ack; after release, re-issued d_rd=0x0300 completes normally.
- MEM_TIMEOUT_EN defined, mem_rdy never asserted → after 15 busy cycles, d_ack=1, err=1, d_rdata=0xFFFF.
- d_rd=d_wr=1, d_addr=0x0050 → single write access with mem_we=1, one d_ack.
